// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_ctrl_pkg : state encodings, instruction type codes and helpers        |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package cpu_ctrl_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WBACK  = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [1:0] TYPE_ALU   = 2'd0;
  localparam logic [1:0] TYPE_IMM   = 2'd1;
  localparam logic [1:0] TYPE_MEMOP = 2'd2;
  localparam logic [1:0] TYPE_BR    = 2'd3;

  function automatic logic is_mem_access(input logic is_load, input logic is_store);
    return is_load | is_store;
  endfunction

  // A load flag wins over a store flag, so only a clean store may write memory.
  function automatic logic is_pure_store(input logic is_load, input logic is_store);
    return is_store & ~is_load;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val == 0) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_ctrl_fsm_mem_wait_cnt.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_wait_cnt : loadable saturating down-counter, done when count is zero  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module mem_wait_cnt
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned MAX_VAL = 0,
  parameter int unsigned CNT_W   = cnt_width(MAX_VAL)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !done) begin
      count <= count - CNT_W'(1);
    end
  end

  assign done = (count == '0);

endmodule
`default_nettype wire

// File: rtl/cpu_ctrl_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_ctrl_fsm : multi-cycle fetch/decode/exec/mem/writeback controller     |
// | Optional halt support: define CPU_CTRL_HALT_EN.           Rev 1.0         |
// +--------------------------------------------------------------------------+
module cpu_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned        TYPE_W   = 2,
  parameter logic [TYPE_W-1:0]  IMM_TYPE = TYPE_W'(1),
  parameter int unsigned        MEM_WAIT = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [TYPE_W-1:0]  instr_type,
  input  logic               wb,
  input  logic               is_load,
  input  logic               is_store,
  input  logic               is_branch,
  input  logic               br_taken,
  input  logic               mem_ready,
`ifdef CPU_CTRL_HALT_EN
  input  logic               is_halt,
  input  logic               resume,
  output logic               halted,
`endif
  output logic               pc_en,
  output logic               pc_load,
  output logic               ls_cntl,
  output logic               mem_we,
  output logic               i_en,
  output logic               s_mux_imm,
  output logic               reg_wen,
  output logic               flags_en,
  output logic [STATE_W-1:0] state_o
);

  localparam int unsigned      CNT_W     = cnt_width(MEM_WAIT);
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(MEM_WAIT);

  state_t state;
  logic   cnt_load;
  logic   cnt_dec;
  logic   cnt_done;
  logic   mem_done;

  // The counter is primed every DECODE so it already holds MEM_WAIT on MEM entry.
  assign cnt_load = (state == DECODE);
  assign cnt_dec  = (state == MEM);
  assign mem_done = cnt_done & mem_ready;

  mem_wait_cnt #(
    .MAX_VAL (MEM_WAIT),
    .CNT_W   (CNT_W)
  ) u_wait (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (WAIT_INIT),
    .dec      (cnt_dec),
    .done     (cnt_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH: state <= DECODE;
        DECODE: begin
          if (is_mem_access(is_load, is_store)) begin
            state <= MEM;
          end else begin
            state <= EXEC;
          end
`ifdef CPU_CTRL_HALT_EN
          if (is_halt) begin
            state <= HALT;
          end
`endif
        end
        EXEC: state <= FETCH;
        MEM: begin
          if (mem_done) begin
            state <= WBACK;
          end
        end
        WBACK: state <= FETCH;
`ifdef CPU_CTRL_HALT_EN
        HALT: begin
          if (resume) begin
            state <= FETCH;
          end
        end
`endif
        default: state <= FETCH;
      endcase
    end
  end

  // Moore decode of the registered state, qualified by the current instruction flags.
  always_comb begin
    pc_en     = 1'b0;
    pc_load   = 1'b0;
    ls_cntl   = 1'b1;
    mem_we    = 1'b0;
    i_en      = 1'b0;
    reg_wen   = 1'b0;
    flags_en  = 1'b0;
    s_mux_imm = (instr_type == IMM_TYPE);
`ifdef CPU_CTRL_HALT_EN
    halted    = 1'b0;
`endif
    case (state)
      FETCH: begin
        i_en = 1'b1;
      end
      DECODE: begin
      end
      EXEC: begin
        pc_en    = 1'b1;
        pc_load  = is_branch & br_taken;
        reg_wen  = wb;
        flags_en = ~is_branch;
      end
      MEM: begin
        ls_cntl = 1'b0;
        mem_we  = mem_done & is_pure_store(is_load, is_store);
      end
      WBACK: begin
        ls_cntl = 1'b0;
        pc_en   = 1'b1;
        reg_wen = is_load & wb;
      end
`ifdef CPU_CTRL_HALT_EN
      HALT: begin
        halted = 1'b1;
        pc_en  = resume;
      end
`endif
      default: begin
      end
    endcase

    // Reset must silence every strobe immediately, not just after the next edge.
    if (!rst_n) begin
      pc_en     = 1'b0;
      pc_load   = 1'b0;
      ls_cntl   = 1'b1;
      mem_we    = 1'b0;
      i_en      = 1'b0;
      reg_wen   = 1'b0;
      flags_en  = 1'b0;
      s_mux_imm = 1'b0;
`ifdef CPU_CTRL_HALT_EN
      halted    = 1'b0;
`endif
    end
  end

  assign state_o = state;

endmodule
`default_nettype wire

// File: tb/tb_cpu_ctrl_fsm.sv
`default_nettype none
// tb_cpu_ctrl_fsm: vector table, reset sequences and random instructions
// compared against an instruction-level model of the controller.
module tb_cpu_ctrl_fsm;

  localparam int MW = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] instr_type = 2'd0;
  logic       wb = 1'b0, is_load = 1'b0, is_store = 1'b0;
  logic       is_branch = 1'b0, br_taken = 1'b0, mem_ready = 1'b0;
  logic       pc_en, pc_load, ls_cntl, mem_we, i_en, s_mux_imm, reg_wen, flags_en;
  logic [2:0] state_o;
`ifdef CPU_CTRL_HALT_EN
  logic       is_halt = 1'b0, resume = 1'b0, halted;
`endif

  cpu_ctrl_fsm #(.TYPE_W(2), .IMM_TYPE(2'd1), .MEM_WAIT(MW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr_type (instr_type),
    .wb         (wb),
    .is_load    (is_load),
    .is_store   (is_store),
    .is_branch  (is_branch),
    .br_taken   (br_taken),
    .mem_ready  (mem_ready),
`ifdef CPU_CTRL_HALT_EN
    .is_halt    (is_halt),
    .resume     (resume),
    .halted     (halted),
`endif
    .pc_en      (pc_en),
    .pc_load    (pc_load),
    .ls_cntl    (ls_cntl),
    .mem_we     (mem_we),
    .i_en       (i_en),
    .s_mux_imm  (s_mux_imm),
    .reg_wen    (reg_wen),
    .flags_en   (flags_en),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [1:0] it;
    logic       w, ld, st, br, tk;
    logic [7:0] rdy;
    int         cyc, nwe, nwen, nfen, npcl;
  } vec_t;

  localparam logic [10:0] RST_OUT = 11'b001_0000_0000;

  function automatic logic [10:0] outs();
    return {pc_en, pc_load, ls_cntl, mem_we, i_en, s_mux_imm, reg_wen, flags_en, state_o};
  endfunction

  task automatic check_v(input string name, input logic [10:0] act, input logic [10:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b required %b (pe,pl,ls,we,ie,sm,rw,fe,state)", name, act, exp);
    end
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  // Expected outputs for cycle c of an instruction that spends n cycles in MEM.
  function automatic logic [10:0] model_out(input logic [1:0] it, input logic w, ld, st, br, tk,
                                            input int c, input int n);
    logic pe, pl, ls, we, ie, sm, rw, fe;
    logic [2:0] s;
    pe = 0; pl = 0; ls = 1; we = 0; ie = 0; rw = 0; fe = 0; s = 3'd0;
    sm = (it == 2'd1);
    if (c == 0) ie = 1;
    else if (c == 1) s = 3'd1;
    else if (!(ld | st)) begin s = 3'd2; pe = 1; pl = br & tk; rw = w; fe = ~br; end
    else if (c < 2 + n) begin s = 3'd3; ls = 0; we = st & ~ld & (c == 1 + n); end
    else begin s = 3'd4; ls = 0; pe = 1; rw = ld & w; end
    return {pe, pl, ls, we, ie, sm, rw, fe, s};
  endfunction

  // Runs one instruction from FETCH; rdy[k] is mem_ready in the k-th MEM cycle (bit 7 must be set).
  task automatic run_instr(input logic [1:0] it, input logic w, ld, st, br, tk, input logic [7:0] rdy,
                           output int cyc, output int nwe, output int nwen, output int nfen,
                           output int npcl, output int npe);
    int n, total;
    n = 0;
    if (ld | st) begin
      n = 8;
      for (int k = 7; k >= MW; k--) if (rdy[k]) n = k + 1;
    end
    total = (ld | st) ? 3 + n : 3;
    instr_type = it; wb = w; is_load = ld; is_store = st; is_branch = br; br_taken = tk;
    cyc = 1; nwe = 0; nwen = 0; nfen = 0; npcl = 0; npe = 0;
    for (int c = 0; c < total; c++) begin
      if ((ld | st) && c >= 2 && c < 2 + n) mem_ready = rdy[c-2];
      else mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_v($sformatf("cycle%0d", c), outs(), model_out(it, w, ld, st, br, tk, c, n));
      if (c > 0 && state_o != 3'd0) cyc++;
      nwe += int'(mem_we); nwen += int'(reg_wen); nfen += int'(flags_en);
      npcl += int'(pc_load); npe += int'(pc_en);
      @(posedge clk); #1;
    end
  endtask

  task automatic realign();
    rst_n = 1'b0; #2; rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[9];
    int cyc, nwe, nwen, nfen, npcl, npe;
    tbl[0] = '{2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF,  3, 0, 1, 1, 0};
    tbl[1] = '{2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF,  3, 0, 0, 0, 1};
    tbl[2] = '{2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF,  3, 0, 0, 0, 0};
    tbl[3] = '{2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hF8,  7, 1, 0, 0, 0};
    tbl[4] = '{2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hFF,  6, 0, 1, 0, 0};
    tbl[5] = '{2'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF,  6, 0, 1, 0, 0};
    tbl[6] = '{2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h82, 11, 1, 0, 0, 0};
    tbl[7] = '{2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF,  3, 0, 0, 1, 0};
    tbl[8] = '{2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h84,  6, 0, 0, 0, 0};

    // Reset state before the first edge.
    instr_type = 2'd1;
    #2;
    check_v("reset_idle", outs(), RST_OUT);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_instr(tbl[i].it, tbl[i].w, tbl[i].ld, tbl[i].st, tbl[i].br, tbl[i].tk, tbl[i].rdy,
                cyc, nwe, nwen, nfen, npcl, npe);
      check_i($sformatf("vec%0d_cycles", i), cyc, tbl[i].cyc);
      check_i($sformatf("vec%0d_mem_we", i), nwe, tbl[i].nwe);
      check_i($sformatf("vec%0d_reg_wen", i), nwen, tbl[i].nwen);
      check_i($sformatf("vec%0d_flags_en", i), nfen, tbl[i].nfen);
      check_i($sformatf("vec%0d_pc_load", i), npcl, tbl[i].npcl);
      check_i($sformatf("vec%0d_pc_en", i), npe, 1);
    end

    // Reset asserted during EXEC.
    instr_type = 2'd0; wb = 1'b1; is_load = 1'b0; is_store = 1'b0; is_branch = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_v("exec_before_reset", outs(), 11'b101_0001_1010);
    rst_n = 1'b0; #1;
    check_v("exec_async_reset", outs(), RST_OUT);
    @(posedge clk); #1;
    check_v("exec_reset_held", outs(), RST_OUT);
    rst_n = 1'b1;
    @(negedge clk);
    check_v("release_fetch", outs(), 11'b001_0100_0000);
    @(posedge clk); #1;
    @(negedge clk);
    check_v("release_decode", outs(), 11'b001_0000_0001);
    @(posedge clk); #1;
    realign();

    // Reset in the completing MEM cycle of a store aborts the write.
    instr_type = 2'd2; wb = 1'b0; is_load = 1'b0; is_store = 1'b1; mem_ready = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    check_v("store_completing", outs(), 11'b000_1000_0011);
    rst_n = 1'b0; #1;
    check_v("mem_abort", outs(), RST_OUT);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_v("mem_abort_fetch", outs(), 11'b001_0100_0000);
    @(posedge clk); #1;
    realign();

`ifdef CPU_CTRL_HALT_EN
    instr_type = 2'd0; is_load = 1'b0; is_store = 1'b0; is_halt = 1'b1;
    @(posedge clk); #1; @(posedge clk); #1;
    repeat (3) begin @(posedge clk); #1; end
    check_i("halt_state", int'(state_o), 5);
    check_i("halted_flag", int'(halted), 1);
    check_i("halt_no_pc", int'(pc_en), 0);
    resume = 1'b1; #1;
    check_i("resume_pc_en", int'(pc_en), 1);
    @(posedge clk); #1;
    resume = 1'b0;
    check_i("resume_fetch", int'(state_o), 0);
    @(posedge clk); #1; @(posedge clk); #1;
    check_i("halted_again", int'(halted), 1);
    rst_n = 1'b0; #1;
    check_i("halt_reset", int'(halted), 0);
    rst_n = 1'b1; is_halt = 1'b0;
    @(posedge clk); #1;
    realign();
`endif

    for (int r = 0; r < 150; r++) begin
      logic [1:0] it;
      logic w, ld, st, br, tk;
      logic [7:0] rdy;
      it = 2'($urandom_range(0, 3));
      w = 1'($urandom); ld = 1'($urandom); st = 1'($urandom);
      br = 1'($urandom); tk = 1'($urandom);
      rdy = 8'($urandom) | 8'h80;
      run_instr(it, w, ld, st, br, tk, rdy, cyc, nwe, nwen, nfen, npcl, npe);
      check_i($sformatf("rand%0d_pc_en_once", r), npe, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
